cpld_spi_responder: RTL

//  SPI mode-0 responder in the CPLD, driven by the CPU SPI1 master (1V8 bank). Gives the CPU

---
 rtl/cpld_defs.sv | 9 +
 rtl/cpld_sync_edge.sv | 23 ++
 rtl/cpld_spi_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpld_defs.sv
// cpld_defs: shared frame, address and state constants for the CPLD SPI responder.
package cpld_defs;
  localparam int         FRAME_W   = 16;
  localparam int         HDR_W     = 8;
  localparam logic [6:0] CTRL_BASE = 7'h40;
  localparam logic [6:0] ID_ADDR   = 7'h7F;
  localparam logic [4:0] CNT_MAX   = 5'd17;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_e;
endpackage

// File: rtl/cpld_sync_edge.sv
// cpld_sync_edge: 2-flop synchroniser with rise/fall detect from a third flop.
//   clk_i, rst_ni   oscillator clock, synchronous active-low reset
//   d_i             asynchronous input
//   q_o             synchronised level
//   rise_o, fall_o  one-cycle pulses on synchronised edges
module cpld_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sync_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) sync_q <= {3{RST_VAL}};
    else sync_q <= {sync_q[1:0], d_i};
  assign q_o    = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/cpld_spi_responder.sv
// cpld_spi_responder: SPI mode-0 responder giving the CPU read access to status bytes and write access to control registers.
//   sysclk, reset_INV          oscillator clock, synchronous active-low reset
//   spi_clk/spi_mosi/spi_cs_INV asynchronous SPI inputs, oversampled on sysclk
//   spi_miso                   read data, 0 outside the data phase of a read frame
//   status_in                  NUM_STATUS status bytes at 0x00.., ID_VALUE at 0x7F
//   ctrl_out                   NUM_CTRL control bytes at 0x40..
//   wr_strobe, wr_addr         one-cycle commit pulse and address of the last commit
//   frame_err                  one-cycle pulse when a frame ends without exactly 16 clocks
// Define CPLD_SPI_WRITE_EN to build the control-register write path.
module cpld_spi_responder
  import cpld_defs::*;
#(
  parameter int         NUM_STATUS = 4,
  parameter int         NUM_CTRL   = 2,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic                    sysclk,
  input  logic                    reset_INV,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_cs_INV,
  output logic                    spi_miso,
  input  logic [8*NUM_STATUS-1:0] status_in,
  output logic [8*NUM_CTRL-1:0]   ctrl_out,
  output logic                    wr_strobe,
  output logic [6:0]              wr_addr,
  output logic                    frame_err
);
  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, hdr, rd_byte;
  logic [1:0] mosi_q;
  logic       miso_q, miso_d, err_q, err_d;
  logic       sclk_rise, sclk_fall, unused_sclk_lvl, cs_lvl, cs_rise, cs_fall;
  logic       bit_rise, hdr_rise, last_rise, end_frame;
  cpld_sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk_i(sysclk), .rst_ni(reset_INV), .d_i(spi_clk),
    .q_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  // Chip select resets inactive so leaving reset never looks like a frame start.
  cpld_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clk_i(sysclk), .rst_ni(reset_INV), .d_i(spi_cs_INV),
    .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  assign bit_rise  = sclk_rise & ~cs_lvl & (state_q != IDLE);
  assign hdr_rise  = bit_rise & (state_q == HDR) & (cnt_q == 5'(HDR_W - 1));
  assign last_rise = bit_rise & (state_q == DATA) & (cnt_q == 5'(FRAME_W - 1));
  assign end_frame = cs_rise & (state_q != IDLE);
  // Header byte as it stands at the 8th rise: seven shifted bits plus the current MOSI.
  assign hdr       = {rx_q[6:0], mosi_q[1]};
  always_ff @(posedge sysclk)
    if (!reset_INV) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      mosi_q  <= '0;
      miso_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      mosi_q  <= {mosi_q[0], spi_mosi};
      miso_q  <= miso_d;
      err_q   <= err_d;
    end
  always_comb begin
    state_d = cs_lvl ? IDLE :
              (state_q == IDLE && cs_fall) ? HDR :
              hdr_rise ? DATA :
              last_rise ? DONE : state_q;
    cnt_d   = (state_q == IDLE) ? 5'd0 :
              (bit_rise && cnt_q != CNT_MAX) ? cnt_q + 5'd1 : cnt_q;
  end
  always_comb begin
    rd_byte = (hdr[6:0] == ID_ADDR) ? ID_VALUE : 8'h00;
    for (int i = 0; i < NUM_STATUS; i++)
      if (hdr[6:0] == 7'(i)) rd_byte = status_in[8*i +: 8];
    for (int i = 0; i < NUM_CTRL; i++)
      if (hdr[6:0] == CTRL_BASE + 7'(i)) rd_byte = ctrl_out[8*i +: 8];
  end
  // Shifting stops after 16 bits so a 17th clock cannot disturb the captured data.
  always_comb begin
    rx_d   = (bit_rise && cnt_q < 5'(FRAME_W)) ? hdr : rx_q;
    tx_d   = hdr_rise ? (hdr[7] ? rd_byte : 8'h00) :
             (sclk_fall && state_q == DATA) ? {tx_q[6:0], 1'b0} : tx_q;
    miso_d = (cs_lvl || (state_q != DATA && state_q != DONE)) ? 1'b0 :
             sclk_fall ? ((state_q == DATA) ? tx_q[7] : 1'b0) : miso_q;
    err_d  = end_frame && cnt_q != 5'(FRAME_W);
  end
  assign spi_miso  = miso_q;
  assign frame_err = err_q;
`ifdef CPLD_SPI_WRITE_EN
  logic [7:0]            hdr_q;
  logic [8*NUM_CTRL-1:0] ctrl_q;
  logic [6:0]            wr_addr_q;
  logic                  wr_strobe_q, commit;
  assign commit = end_frame && cnt_q == 5'(FRAME_W) && !hdr_q[7] &&
                  hdr_q[6:0] >= CTRL_BASE && hdr_q[6:0] < CTRL_BASE + 7'(NUM_CTRL);
  always_ff @(posedge sysclk)
    if (!reset_INV) begin
      hdr_q       <= '0;
      ctrl_q      <= '0;
      wr_addr_q   <= '0;
      wr_strobe_q <= 1'b0;
    end else begin
      if (hdr_rise) hdr_q <= hdr;
      wr_strobe_q <= commit;
      if (commit) wr_addr_q <= hdr_q[6:0];
      for (int i = 0; i < NUM_CTRL; i++)
        if (commit && hdr_q[6:0] == CTRL_BASE + 7'(i)) ctrl_q[8*i +: 8] <= rx_q;
    end
  assign ctrl_out  = ctrl_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
`else
  logic unused_data;
  assign unused_data = rx_q[7];
  assign ctrl_out    = '0;
  assign wr_strobe   = 1'b0;
  assign wr_addr     = '0;
`endif
endmodule
